// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and legal WIDTH range.
`timescale 1ns/1ps
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/fa_slice.sv
// Single full-adder slice; the only arithmetic in the serial adder.
`timescale 1ns/1ps
module fa_slice (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder, LSB first, WIDTH cycles per operation plus one DONE cycle.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (a - b); otherwise add-only.
`timescale 1ns/1ps
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_n: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             y, s, co, seed, last;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          sub_q <= 1'b0;
    else if (state == ST_IDLE && start) sub_q <= sub;
  end
  // Two's complement subtract: invert b per slice, seed carry with 1.
  assign y    = b_sh[0] ^ sub_q;
  assign seed = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign y          = b_sh[0];
  assign seed       = 1'b0;
`endif

  fa_slice u_fa (
    .x  (a_sh[0]),
    .y  (y),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)  state_nxt = ST_DONE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= seed;
          cnt   <= '0;
        end
        ST_SHIFT: begin
          carry  <= co;
          res_sh <= {s, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          // Result is published only on completion so a reset never leaks a partial sum.
          if (last) begin
            sum  <= {s, res_sh[WIDTH-1:1]};
            cout <= co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: WIDTH=4 and WIDTH=8 instances, hand-computed results.
`timescale 1ns/1ps
module tb_serial_adder_n;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, sub4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       start8 = 1'b0, sub8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation; reports done latency, busy cycles, done pulses and result at k==2.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output int lat, output int bcnt, output int dcnt,
                     output logic [3:0] mid_sum, output logic mid_cout);
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b; sub4 = ~s;
    lat = -1; bcnt = 0; dcnt = 0; mid_sum = 'x; mid_cout = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) begin mid_sum = sum4; mid_cout = cout4; end
      if (busy4) bcnt++;
      if (done4) begin dcnt++; if (lat < 0) lat = k; end
      if (!busy4) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bcnt, dcnt, d0, d1, dn;
    logic [3:0] ms;
    logic mc;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_sum",  sum4,  4'd0);
    chk("rst_cout", cout4, 1'b0);
    rst = 1'b0;

    // 3 + 5
    op4(4'd3, 4'd5, 1'b0, lat, bcnt, dcnt, ms, mc);
    chk("t1_latency", lat, 32'd4);
    chk("t1_busy_cycles", bcnt, 32'd5);
    chk("t1_done_pulses", dcnt, 32'd1);
    chk("t1_sum", sum4, 4'd8);
    chk("t1_cout", cout4, 1'b0);

    // 15 + 1 wraps with carry out, then 0 + 0 while the old result holds
    op4(4'd15, 4'd1, 1'b0, lat, bcnt, dcnt, ms, mc);
    chk("t2a_sum", sum4, 4'd0);
    chk("t2a_cout", cout4, 1'b1);
    op4(4'd0, 4'd0, 1'b0, lat, bcnt, dcnt, ms, mc);
    chk("t2b_hold_cout", mc, 1'b1);
    chk("t2b_sum", sum4, 4'd0);
    chk("t2b_cout", cout4, 1'b0);

    // Start during SHIFT is ignored
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd4; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (done4) dcnt++;
      @(negedge clk);
    end
    chk("t3_done_pulses", dcnt, 32'd1);
    chk("t3_sum", sum4, 4'd6);
    chk("t3_busy_idle", busy4, 1'b0);

    // Reset mid-SHIFT discards the partial result
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_sum", sum4, 4'd0);
    chk("t4_rst_cout", cout4, 1'b0);
    chk("t4_rst_busy", busy4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done4) dcnt++;
      @(negedge clk);
    end
    chk("t4_no_done", dcnt, 32'd0);
    op4(4'd7, 4'd7, 1'b0, lat, bcnt, dcnt, ms, mc);
    chk("t4_sum", sum4, 4'd14);
    chk("t4_cout", cout4, 1'b0);

    // Subtract mode (add-only build treats sub as 0)
    op4(4'd5, 4'd7, 1'b1, lat, bcnt, dcnt, ms, mc);
`ifdef SERIAL_ADDER_SUB_EN
    chk("t5a_sum", sum4, 4'd14);
    chk("t5a_cout", cout4, 1'b0);
`else
    chk("t5a_sum", sum4, 4'd12);
    chk("t5a_cout", cout4, 1'b0);
`endif
    op4(4'd7, 4'd5, 1'b1, lat, bcnt, dcnt, ms, mc);
`ifdef SERIAL_ADDER_SUB_EN
    chk("t5b_sum", sum4, 4'd2);
    chk("t5b_cout", cout4, 1'b1);
`else
    chk("t5b_sum", sum4, 4'd12);
    chk("t5b_cout", cout4, 1'b0);
`endif

    // WIDTH=8, start held high continuously
    chk("t6_rst_sum", sum8, 8'd0);
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(negedge clk);
    d0 = -1; d1 = -1; dn = 0;
    for (int k = 0; k < 30; k++) begin
      if (done8) begin
        if (dn == 0) d0 = k;
        else if (dn == 1) d1 = k;
        dn++;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("t6_first_done", d0, 32'd8);
    chk("t6_second_done", d1, 32'd18);
    chk("t6_sum", sum8, 8'd254);
    chk("t6_cout", cout8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised bit-serial adder that processes one operand bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. It is the successor to the fixed 4-bit serial adder. It adds:

- operand width as a parameter;
- a start/busy/done handshake;
- a parallel-loaded operand shift register;
- a registered parallel result with carry-out;
- optional subtract mode.

It sits between a parallel-operand producer and any consumer that can tolerate WIDTH+2 cycles per operation.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clock clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- sub  input  1  subtract select; captured with the operands. Ignored (treated as 0) unless SERIAL_ADDER_SUB_EN is defined.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse in DONE; sum and cout are valid from this cycle.
- sum  output  WIDTH  result register; holds its value until the next completion.
- cout  output  1  final carry; holds its value until the next completion.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: processes WIDTH bits.
  - DONE: one cycle, pulses done.
- IDLE → SHIFT when start=1. On that edge:
  - a_sh←a, b_sh←b.
  - sub_q←sub.
  - carry←sub_q-value (1 for subtract, else 0).
  - bit counter cnt←0.
- SHIFT, every edge:
  - s = a_sh[0] ^ (b_sh[0]^sub_q) ^ carry.
  - carry ← majority(a_sh[0], b_sh[0]^sub_q, carry).
  - res_sh ← {s, res_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one.
  - cnt++.
- SHIFT → DONE on the edge where cnt==WIDTH-1. On that edge:
  - sum ← final res_sh including the current bit.
  - cout ← the new carry.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE; there is no queuing.
- Arithmetic: sum = (a + b) mod 2^WIDTH and cout = bit WIDTH of the true sum.
- Subtract: sum = (a − b) mod 2^WIDTH; cout=1 means no borrow (a ≥ b unsigned).
- cnt width is $clog2(WIDTH).
- Reset (at any time, including mid-SHIFT):
  - state←IDLE, busy=0, done=0, sum=0, cout=0.
  - carry, cnt and all shift registers ← 0.
  - A partial result is discarded and never appears on sum.

## Timing
- Start accepted at edge E0: busy=1 from E0 onward.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- DONE is entered at E_WIDTH; done=1 for exactly one cycle after E_WIDTH, with sum and cout updated at the same edge.
- E_WIDTH+1: IDLE, busy=0.
- Latency from the start edge to done: WIDTH cycles.
- Minimum start-to-start spacing: WIDTH+2 cycles. A start held high continuously is re-accepted at the first edge in IDLE.
- a, b and sub need to be valid only at the accepting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub is honoured.
  - b bits are inverted per slice and the carry is seeded with 1.
- SERIAL_ADDER_SUB_EN undefined:
  - the sub_q flop and the XOR are not built.
  - the carry seed is always 0 and the block is add-only.
  - The sub port remains, unconnected internally, so the instantiation is identical in both builds.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the WIDTH range check constants.
- The per-bit full adder is a combinational sub-module fa_slice with inputs x, y, ci and outputs s, co.
- The FSM, counter and shift registers live in serial_adder_n.

## Test plan
- WIDTH=4, a=3, b=5, start one cycle → done pulses exactly 4 cycles after the start edge with sum=8, cout=0; busy is high for 5 cycles.
- WIDTH=4, a=15, b=1 → sum=0, cout=1. Then a=0, b=0 → sum=0, cout=0; the previous result holds until this done.
- WIDTH=4: start, then start pulsed again in SHIFT with a=9 → ignored; result is the first operation only; no extra done.
- WIDTH=4, a=7, b=7: assert rst two edges after start → sum=0, cout=0, busy=0 immediately. No done follows; a new start after reset release gives sum=14.
- SERIAL_ADDER_SUB_EN, WIDTH=4: 5−7 → sum=14, cout=0; 7−5 → sum=2, cout=1. Without the macro, sub=1 with 7,5 → sum=12.
- WIDTH=8, a=255, b=255 → done 8 cycles after start, sum=254, cout=1. Start held high continuously → operations complete every 10 cycles.
